// File: rtl/cpu_defines_pkg.sv
// Shared CPU-wide widths and sizing constants for the fetch/decode path.
// Ports: none (package only).
// Imported by the instruction fetch queue and its neighbours.
package cpu_defines;

  localparam int INST_FIFO_DEPTH = 16;
  localparam int INST_W          = 32;
  localparam int PC_W            = 32;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Dual-push / dual-pop instruction queue between i-cache and dual-issue decode.
// Latency: a pushed entry appears on out_* the cycle after the push edge (no bypass);
//   outputs are combinational from registered pointers/count.
// Backpressure: almost_full (fewer than 2 free slots) stalls fetch; an overflowing
//   push is dropped whole. Pops are gated by out_valid1/2, so over-popping is harmless.
// Ports: clk, rst (sync, active-high), flush; push_en1/2 + push_inst1/2 + push_pc1/2;
//   pop_en1/2; out_valid1/2 + out_inst1/2 + out_pc1/2; empty, almost_full, count.
module inst_fetch_fifo
  import cpu_defines::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push_en1,
  input  logic              push_en2,
  input  logic [INST_W-1:0] push_inst1,
  input  logic [PC_W-1:0]   push_pc1,
  input  logic [INST_W-1:0] push_inst2,
  input  logic [PC_W-1:0]   push_pc2,
  input  logic              pop_en1,
  input  logic              pop_en2,
  output logic              out_valid1,
  output logic [INST_W-1:0] out_inst1,
  output logic [PC_W-1:0]   out_pc1,
  output logic              out_valid2,
  output logic [INST_W-1:0] out_inst2,
  output logic [PC_W-1:0]   out_pc2,
  output logic              empty,
  output logic              almost_full,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_X = (PTR_W+2)'(DEPTH);

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];

  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W-1:0] wptr_p1, rptr_p1;
  logic [1:0]       num_push_req, num_push, num_pop;
  logic             overflow, pop1, pop2, wr1, wr2;

  assign wptr_p1 = wptr + PTR_W'(1);
  assign rptr_p1 = rptr + PTR_W'(1);

  // Slot 2 alone is not a legal request; treat it as no push at all.
  always_comb begin
    num_push_req = 2'd0;
    if (push_en1) num_push_req = push_en2 ? 2'd2 : 2'd1;
  end

  // Overflow check ignores same-cycle pops: fetch is expected to honour almost_full.
  assign overflow = ({1'b0, count} + (PTR_W+2)'(num_push_req)) > DEPTH_X;
  assign num_push = overflow ? 2'd0 : num_push_req;
  assign wr1      = num_push != 2'd0;
  assign wr2      = num_push == 2'd2;

  assign pop1    = pop_en1 & out_valid1;
  assign pop2    = pop_en2 & pop1 & out_valid2;
  assign num_pop = {1'b0, pop1} + {1'b0, pop2};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PTR_W'(num_push);
      rptr  <= rptr + PTR_W'(num_pop);
      count <= count + (PTR_W+1)'(num_push) - (PTR_W+1)'(num_pop);
    end
  end

  // Storage is not reset; a flush only has to suppress the writes.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (wr1) begin
        mem_inst[wptr] <= push_inst1;
        mem_pc[wptr]   <= push_pc1;
      end
      if (wr2) begin
        mem_inst[wptr_p1] <= push_inst2;
        mem_pc[wptr_p1]   <= push_pc2;
      end
    end
  end

  assign out_valid1  = count >= (PTR_W+1)'(1);
  assign out_valid2  = count >= (PTR_W+1)'(2);
  assign out_inst1   = mem_inst[rptr];
  assign out_pc1     = mem_pc[rptr];
  assign out_inst2   = mem_inst[rptr_p1];
  assign out_pc2     = mem_pc[rptr_p1];
  assign empty       = count == '0;
  assign almost_full = (DEPTH_C - count) < (PTR_W+1)'(2);

endmodule

// File: tb/tb_inst_fetch_fifo.sv
// Directed bench for inst_fetch_fifo: reset, dual push/pop, fill and overflow drop,
// pointer wrap, flush priority, pop gating at low occupancy and mid-run reset.
// Ports: none (top-level bench).
module tb_inst_fetch_fifo;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        push_en1, push_en2, pop_en1, pop_en2;
  logic [31:0] push_inst1, push_pc1, push_inst2, push_pc2;
  logic        out_valid1, out_valid2, empty, almost_full;
  logic [31:0] out_inst1, out_pc1, out_inst2, out_pc2;
  logic [4:0]  count;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_fifo #(.DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_en1(push_en1), .push_en2(push_en2),
    .push_inst1(push_inst1), .push_pc1(push_pc1),
    .push_inst2(push_inst2), .push_pc2(push_pc2),
    .pop_en1(pop_en1), .pop_en2(pop_en2),
    .out_valid1(out_valid1), .out_inst1(out_inst1), .out_pc1(out_pc1),
    .out_valid2(out_valid2), .out_inst2(out_inst2), .out_pc2(out_pc2),
    .empty(empty), .almost_full(almost_full), .count(count)
  );

  // Slot 2 must never be requested without slot 1.
  always @(posedge clk) begin
    assert (!(push_en2 && !push_en1)) else $error("push_en2 without push_en1");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0;
    push_en1 = 1'b0; push_en2 = 1'b0; pop_en1 = 1'b0; pop_en2 = 1'b0;
  endtask

  // One clock with the given request; inputs return to idle and outputs are
  // sampled 1 time unit after the edge.
  task automatic cyc(input bit e1, input bit e2, input logic [31:0] pc1,
                     input logic [31:0] pc2, input bit p1, input bit p2);
    push_en1 = e1; push_en2 = e2;
    push_pc1 = pc1; push_inst1 = ~pc1;
    push_pc2 = pc2; push_inst2 = ~pc2;
    pop_en1 = p1; pop_en2 = p2;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    push_inst1 = '0; push_pc1 = '0; push_inst2 = '0; push_pc2 = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_v1", 32'(out_valid1), 32'd0);
    check("rst_v2", 32'(out_valid2), 32'd0);

    // First dual push with real instruction words.
    push_en1 = 1; push_en2 = 1;
    push_inst1 = 32'h24010001; push_pc1 = 32'hBFC00000;
    push_inst2 = 32'h24020002; push_pc2 = 32'hBFC00004;
    @(posedge clk); #1;
    idle_inputs();
    check("dp_v1", 32'(out_valid1), 32'd1);
    check("dp_v2", 32'(out_valid2), 32'd1);
    check("dp_pc1", out_pc1, 32'hBFC00000);
    check("dp_pc2", out_pc2, 32'hBFC00004);
    check("dp_inst1", out_inst1, 32'h24010001);
    check("dp_inst2", out_inst2, 32'h24020002);
    check("dp_count", 32'(count), 32'd2);

    // Fill to 14: two free slots remain, so not yet almost full.
    for (int i = 0; i < 6; i++) cyc(1, 1, 32'h1000 + 32'(8*i), 32'h1004 + 32'(8*i), 0, 0);
    check("fill14_count", 32'(count), 32'd14);
    check("fill14_af", 32'(almost_full), 32'd0);
    cyc(1, 0, 32'h2000, 32'h0, 0, 0);
    check("fill15_count", 32'(count), 32'd15);
    check("fill15_af", 32'(almost_full), 32'd1);
    cyc(1, 1, 32'h3000, 32'h3004, 0, 0);
    check("ovf_drop_count", 32'(count), 32'd15);
    cyc(1, 0, 32'h2008, 32'h0, 0, 0);
    check("full_count", 32'(count), 32'd16);
    check("full_af", 32'(almost_full), 32'd1);
    check("full_head_pc", out_pc1, 32'hBFC00000);

    // Flush to restart from pointers 0, then occupancy 3 with dual pop + dual push.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush16_count", 32'(count), 32'd0);
    cyc(1, 1, 32'hA0, 32'hA4, 0, 0);
    cyc(1, 0, 32'hA8, 32'h0, 0, 0);
    check("c3_count", 32'(count), 32'd3);
    cyc(1, 1, 32'hB0, 32'hB4, 1, 1);
    check("pp_count", 32'(count), 32'd3);
    check("pp_pc1", out_pc1, 32'hA8);
    check("pp_pc2", out_pc2, 32'hB0);

    // Drain (rptr 2->5), then advance both pointers to 15 for the wrap test.
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    check("drain_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 32'hC00 + 32'(8*i), 32'hC04 + 32'(8*i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 1);
    check("pre_wrap_count", 32'(count), 32'd0);
    cyc(1, 1, 32'h100, 32'h104, 0, 0);
    check("wrap_pc1", out_pc1, 32'h100);
    check("wrap_pc2", out_pc2, 32'h104);
    check("wrap_inst2", out_inst2, ~32'h104);
    cyc(0, 0, 0, 0, 1, 0);
    check("wrap_idx0_pc", out_pc1, 32'h104);
    check("wrap_c1_count", 32'(count), 32'd1);

    // count=1 with a dual pop: only one entry leaves, rptr moves by one.
    cyc(0, 0, 0, 0, 1, 1);
    check("underflow_count", 32'(count), 32'd0);
    check("underflow_empty", 32'(empty), 32'd1);
    cyc(1, 0, 32'h200, 32'h0, 0, 0);
    check("underflow_rptr_pc", out_pc1, 32'h200);

    // count=5, then flush with a concurrent push and pop.
    cyc(1, 1, 32'h210, 32'h214, 0, 0);
    cyc(1, 1, 32'h218, 32'h21C, 0, 0);
    check("c5_count", 32'(count), 32'd5);
    flush = 1'b1;
    push_en1 = 1'b1; push_pc1 = 32'h999; push_inst1 = ~32'h999;
    pop_en1 = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_v1", 32'(out_valid1), 32'd0);
    cyc(1, 0, 32'h300, 32'h0, 0, 0);
    check("post_flush_pc1", out_pc1, 32'h300);
    check("post_flush_count", 32'(count), 32'd1);

    // Mid-run reset from almost-full clears everything.
    for (int i = 0; i < 7; i++) cyc(1, 1, 32'h400 + 32'(8*i), 32'h404 + 32'(8*i), 0, 0);
    check("pre_rst_af", 32'(almost_full), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_af", 32'(almost_full), 32'd0);
    check("mid_rst_v1", 32'(out_valid1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
